// File: rtl/alu_issue_stage.sv
// Issue stage that feeds an external combinational 64-bit ALU.
// It has two valid/ready stages: E (operands and ALU drive) and W (registered result).
module alu_issue_stage #(
  parameter int DATAPATH_WIDTH = 64,
  parameter int TAG_WIDTH      = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic [DATAPATH_WIDTH-1:0] in_a,
  input  logic [DATAPATH_WIDTH-1:0] in_b,
  input  logic                      in_chain,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic [DATAPATH_WIDTH-1:0] alu_a_out,
  output logic [DATAPATH_WIDTH-1:0] alu_b_out,
  output logic [3:0]                alu_ctrl_out,
  input  logic [DATAPATH_WIDTH-1:0] alu_result_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATAPATH_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_err,
  output logic [COUNT_WIDTH-1:0]    op_count
);

  localparam logic [3:0] OP_MAX = 4'd4;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_MAX;
  endfunction

  logic                      e_valid_q, e_valid_d;
  logic [3:0]                e_op_q, e_op_d;
  logic [DATAPATH_WIDTH-1:0] e_a_q, e_a_d;
  logic [DATAPATH_WIDTH-1:0] e_b_q, e_b_d;
  logic                      e_chain_q, e_chain_d;
  logic [TAG_WIDTH-1:0]      e_tag_q, e_tag_d;

  logic                      out_valid_q, out_valid_d;
  logic [DATAPATH_WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_WIDTH-1:0]      out_tag_q, out_tag_d;
  logic                      out_err_q, out_err_d;
  logic [COUNT_WIDTH-1:0]    op_count_q, op_count_d;
  logic [DATAPATH_WIDTH-1:0] last_result_q, last_result_d;

  logic w_adv, e_adv, accept;

  always_comb begin
    w_adv    = !out_valid_q || out_ready;
    e_adv    = e_valid_q && w_adv;
    in_ready = !e_valid_q || e_adv;
    accept   = in_valid && in_ready;

    e_valid_d     = e_valid_q;
    e_op_d        = e_op_q;
    e_a_d         = e_a_q;
    e_b_d         = e_b_q;
    e_chain_d     = e_chain_q;
    e_tag_d       = e_tag_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_tag_d     = out_tag_q;
    out_err_d     = out_err_q;
    op_count_d    = op_count_q;
    last_result_d = last_result_q;

    // E stage: capture the request
    if (accept) begin
      e_valid_d = 1'b1;
      e_op_d    = in_op;
      e_a_d     = in_a;
      e_b_d     = in_b;
      e_chain_d = in_chain;
      e_tag_d   = in_tag;
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end

    // W stage: capture the ALU result; last_result is visible to a chained op entering E on this edge
    if (e_adv) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_result_in;
      out_tag_d     = e_tag_q;
      out_err_d     = op_illegal(e_op_q);
      last_result_d = alu_result_in;
    end else if (w_adv) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q     <= 1'b0;
      e_op_q        <= '0;
      e_a_q         <= '0;
      e_b_q         <= '0;
      e_chain_q     <= 1'b0;
      e_tag_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_err_q     <= 1'b0;
      op_count_q    <= '0;
      last_result_q <= '0;
    end else begin
      e_valid_q     <= e_valid_d;
      e_op_q        <= e_op_d;
      e_a_q         <= e_a_d;
      e_b_q         <= e_b_d;
      e_chain_q     <= e_chain_d;
      e_tag_q       <= e_tag_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_tag_q     <= out_tag_d;
      out_err_q     <= out_err_d;
      op_count_q    <= op_count_d;
      last_result_q <= last_result_d;
    end
  end

  assign alu_ctrl_out = e_op_q;
  assign alu_b_out    = e_b_q;
  assign alu_a_out    = e_chain_q ? last_result_q : e_a_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_tag      = out_tag_q;
  assign out_err      = out_err_q;
  assign op_count     = op_count_q;

endmodule
